// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared types and helpers for the PLL lock supervisor.
//   pll_sup_state_t : supervisor FSM state encoding (also exported on state_o)
//   LOL_W           : width of the optional loss-of-lock counter
//   lol_sat_inc     : saturating increment for the loss-of-lock counter
// -----------------------------------------------------------------------------
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_sup_state_t;

    localparam int LOL_W = 8;

    // Saturating +1: holds at all-ones instead of wrapping to zero.
    function automatic logic [LOL_W-1:0] lol_sat_inc(input logic [LOL_W-1:0] v);
        logic [LOL_W-1:0] r;
        if (v == {LOL_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(LOL_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk   in  destination clock
//   rst_n in  synchronous active-low reset; both flops load RESET_VAL
//   d     in  asynchronous input
//   q     out synchronised output, d delayed by two clk edges
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences the fabric PLL: holds its reset, waits for lock, qualifies lock
// stability, then releases the downstream reset request. Loss of lock re-resets
// the PLL; too many failed lock attempts park the block in FAULT until
// clear_fault or rst_n. Runs entirely in the refclk domain.
//
// Optional feature macro: PLL_SUP_LOL_CNT_EN adds the lol_cnt port and a
// saturating counter of RUN exits caused by loss of lock.
//
// Ports:
//   refclk      in   reference clock (single clock domain)
//   rst_n       in   synchronous active-low reset
//   pll_locked  in   PLL lock indication, asynchronous
//   relock_req  in   pulse: restart the PLL reset sequence (ignored in FAULT)
//   clear_fault in   pulse: leave FAULT with retries cleared (ignored elsewhere)
//   pll_rst     out  PLL reset, active high
//   sys_rst_n   out  downstream reset request, high only in RUN
//   fault       out  high while in FAULT
//   state_o     out  current state encoding
//   lol_cnt     out  saturating loss-of-lock count (macro builds only)
// -----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 5000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             relock_req,
    input  logic             clear_fault,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             fault,
    output logic [2:0]       state_o
`ifdef PLL_SUP_LOL_CNT_EN
    ,
    output logic [LOL_W-1:0] lol_cnt
`endif
);

    // Retry counter only needs to reach MAX_RETRIES.
    localparam int RTRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam longint CNT_LIM = longint'(1) << CNT_W;

    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RTRY_W-1:0] RETRY_MAX   = RTRY_W'(MAX_RETRIES);

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [RTRY_W-1:0] RTRY_ZERO = {RTRY_W{1'b0}};
    localparam logic [RTRY_W-1:0] RTRY_ONE  = {{(RTRY_W-1){1'b0}}, 1'b1};

    // Elaboration-time parameter sanity check.
    if ((RST_CYCLES < 1) || (LOCK_TIMEOUT < 1) || (STABLE_CYCLES < 1) ||
        (MAX_RETRIES < 0) ||
        (longint'(RST_CYCLES) >= CNT_LIM) ||
        (longint'(LOCK_TIMEOUT) >= CNT_LIM) ||
        (longint'(STABLE_CYCLES) >= CNT_LIM)) begin : g_param_check
        $error("pll_lock_supervisor: illegal parameter combination");
    end

    pll_sup_state_t    state_r;
    pll_sup_state_t    next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [RTRY_W-1:0] retries_r;
    logic [RTRY_W-1:0] retries_next_s;
    logic              locked_s;
`ifdef PLL_SUP_LOL_CNT_EN
    logic              lol_evt_s;
`endif

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Saturating increment of the shared cycle counter.
    always_comb begin
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
    end

    // Next-state, counter and retry logic; relock_req outranks all FSM events.
    always_comb begin
        next_state_s   = state_r;
        cnt_next_s     = cnt_inc_s;
        retries_next_s = retries_r;
`ifdef PLL_SUP_LOL_CNT_EN
        lol_evt_s      = 1'b0;
`endif
        if (relock_req && (state_r != FAULT)) begin
            next_state_s = RESET_PLL;
            cnt_next_s   = CNT_ZERO;
        end else begin
            case (state_r)
                RESET_PLL: begin
                    if (cnt_r == RST_LAST) begin
                        next_state_s = WAIT_LOCK;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        next_state_s = RESET_PLL;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        next_state_s = STABLE;
                        cnt_next_s   = CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_next_s = CNT_ZERO;
                        if (retries_r == RETRY_MAX) begin
                            next_state_s = FAULT;
                        end else begin
                            next_state_s   = RESET_PLL;
                            retries_next_s = retries_r + RTRY_ONE;
                        end
                    end else begin
                        next_state_s = WAIT_LOCK;
                    end
                end
                STABLE: begin
                    // A glitch restarts the timeout window without costing a retry.
                    if (!locked_s) begin
                        next_state_s = WAIT_LOCK;
                        cnt_next_s   = CNT_ZERO;
                    end else if (cnt_r == STABLE_LAST) begin
                        next_state_s   = RUN;
                        cnt_next_s     = CNT_ZERO;
                        retries_next_s = RTRY_ZERO;
                    end else begin
                        next_state_s = STABLE;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        next_state_s = RESET_PLL;
                        cnt_next_s   = CNT_ZERO;
`ifdef PLL_SUP_LOL_CNT_EN
                        lol_evt_s    = 1'b1;
`endif
                    end else begin
                        next_state_s = RUN;
                    end
                end
                FAULT: begin
                    if (clear_fault) begin
                        next_state_s   = RESET_PLL;
                        cnt_next_s     = CNT_ZERO;
                        retries_next_s = RTRY_ZERO;
                    end else begin
                        next_state_s = FAULT;
                    end
                end
                default: begin
                    next_state_s   = RESET_PLL;
                    cnt_next_s     = CNT_ZERO;
                    retries_next_s = RTRY_ZERO;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state so they move with it.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_r   <= RESET_PLL;
            cnt_r     <= CNT_ZERO;
            retries_r <= RTRY_ZERO;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= cnt_next_s;
            retries_r <= retries_next_s;
            pll_rst   <= (next_state_s == RESET_PLL) || (next_state_s == FAULT);
            sys_rst_n <= (next_state_s == RUN);
            fault     <= (next_state_s == FAULT);
        end
    end

    assign state_o = state_r;

`ifdef PLL_SUP_LOL_CNT_EN
    // Loss-of-lock counter; cleared only by rst_n.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lol_cnt <= {LOL_W{1'b0}};
        end else if (lol_evt_s) begin
            lol_cnt <= lol_sat_inc(lol_cnt);
        end else begin
            lol_cnt <= lol_cnt;
        end
    end
`endif

endmodule
